// File: rtl/noc_input_buffer.sv
// noc_input_buffer
//   Per-direction input stage of the 5-port NoC router. Buffers incoming flits in a
//   FIFO, parses packet framing from the head flit, requests the arbiter and forwards
//   flits to the crossbar one per cycle while this port holds the grant.
// Ports
//   clk, rst            clock (posedge) and synchronous active-high reset
//   in_valid, in_flit   upstream flit; accepted when in_ready is high
//   in_ready            FIFO not full
//   grant               this port's bit of the arbiter one-hot state
//   req                 packet pending or in flight (registered state != IDLE)
//   flit_id             id field of the FIFO head flit, 3'b000 when empty
//   length              length field latched from the current header
//   out_valid, out_flit registered forwarded flit to the crossbar
//   err                 one-cycle pulse on a framing error
module noc_input_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_flit,
    output logic              in_ready,
    input  logic              grant,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_flit,
    output logic              err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] XFER = 2'b10;

    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;

    logic [1:0]        state, state_next;
    logic [11:0]       length_next;
    logic              err_next;

    logic [DATA_W-1:0] head;
    logic [2:0]        head_id;
    logic              empty, push, pop, pop_fwd, discard;

    assign head     = mem[rd_ptr];
    assign head_id  = head[DATA_W-1:DATA_W-3];
    assign empty    = (count == '0);
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign flit_id  = empty ? 3'b000 : head_id;
    assign req      = (state != IDLE);

    // Forwarding pops only under grant; IDLE pops drop stray non-header flits.
    assign pop_fwd  = grant & (state != IDLE) & ~empty;
    assign pop      = pop_fwd | discard;

    always_comb begin
        state_next  = state;
        length_next = length;
        discard     = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (head_id == ID_HEAD) begin
                        length_next = head[11:0];
                        state_next  = REQ;
                    end else begin
                        discard  = 1'b1;
                        err_next = 1'b1;
                    end
                end
            end
            REQ: begin
                // Head is the header that moved us here; popping it starts the transfer.
                if (pop_fwd) state_next = XFER;
            end
            XFER: begin
                if (pop_fwd) begin
                    if (head_id == ID_TAIL) begin
                        state_next = IDLE;
                    end else if (head_id != ID_BODY) begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            length    <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            err       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            state     <= state_next;
            length    <= length_next;
            err       <= err_next;
            out_valid <= pop_fwd;
            if (pop_fwd) out_flit <= head;
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer
//   Directed bench for noc_input_buffer (DATA_W=32, DEPTH=8). Inputs are driven 1 time
//   unit after the rising edge and outputs are checked at that same point; a negedge
//   monitor collects every forwarded flit and counts err pulses.
module tb_noc_input_buffer;

    localparam logic [2:0] ID_HEAD = 3'b001;
    localparam logic [2:0] ID_BODY = 3'b010;
    localparam logic [2:0] ID_TAIL = 3'b100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_flit;
    logic        in_ready;
    logic        grant;
    logic        req;
    logic [2:0]  flit_id;
    logic [11:0] length;
    logic        out_valid;
    logic [31:0] out_flit;
    logic        err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_err   = 0;
    logic [31:0] got [$];

    noc_input_buffer #(.DATA_W(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .grant     (grant),
        .req       (req),
        .flit_id   (flit_id),
        .length    (length),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid) got.push_back(out_flit);
        if (!rst && err) n_err++;
    end

    function automatic logic [31:0] mk(input logic [2:0] id, input int tag, input int len);
        logic [16:0] t;
        logic [11:0] l;
        t = tag[16:0];
        l = len[11:0];
        return {id, t, l};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && req; k++) tick();
        chk(tag, 32'(req), 32'd0);
    endtask

    logic [31:0] f2 [8];
    logic [31:0] f4 [4];
    logic        g4 [6];
    logic [31:0] f5 [60];
    logic        acc;
    int          idx;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_flit  = '0;
        grant    = 1'b0;
        tick();
        tick();
        chk("rst_req",       32'(req),       32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_flit",  out_flit,       32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_length",    32'(length),    32'd0);
        chk("rst_flit_id",   32'(flit_id),   32'd0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // 1: H(len=5), B, T back to back with grant held high
        grant = 1'b1;
        in_valid = 1'b1;
        in_flit = mk(ID_HEAD, 1, 5);
        tick();
        chk("t1_head_id",    32'(flit_id),   32'(ID_HEAD));
        chk("t1_req_early",  32'(req),       32'd0);
        in_flit = mk(ID_BODY, 2, 0);
        tick();
        chk("t1_req",        32'(req),       32'd1);
        chk("t1_length",     32'(length),    32'd5);
        in_flit = mk(ID_TAIL, 3, 0);
        tick();
        in_valid = 1'b0;
        chk("t1_ov0",        32'(out_valid), 32'd1);
        chk("t1_of0",        out_flit,       mk(ID_HEAD, 1, 5));
        tick();
        chk("t1_ov1",        32'(out_valid), 32'd1);
        chk("t1_of1",        out_flit,       mk(ID_BODY, 2, 0));
        tick();
        chk("t1_ov2",        32'(out_valid), 32'd1);
        chk("t1_of2",        out_flit,       mk(ID_TAIL, 3, 0));
        chk("t1_req_drop",   32'(req),       32'd0);
        tick();
        chk("t1_ov_end",     32'(out_valid), 32'd0);
        chk("t1_err_cnt",    32'(n_err),     32'd0);

        // 2: fill all 8 entries with grant low, try a 9th, then drain
        grant = 1'b0;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            f2[i] = mk((i == 0) ? ID_HEAD : ((i == 7) ? ID_TAIL : ID_BODY), 16 + i, 8);
        end
        for (int i = 0; i < 8; i++) begin
            chk("t2_ready_fill", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_flit  = f2[i];
            tick();
        end
        chk("t2_full",       32'(in_ready),  32'd0);
        in_flit = mk(ID_BODY, 99, 0);
        tick();
        in_valid = 1'b0;
        chk("t2_still_full", 32'(in_ready),  32'd0);
        chk("t2_req_nogrant", 32'(req),      32'd1);
        grant = 1'b1;
        tick();
        grant = 1'b0;
        chk("t2_ready_back", 32'(in_ready),  32'd1);
        chk("t2_first_ov",   32'(out_valid), 32'd1);
        chk("t2_first_of",   out_flit,       f2[0]);
        grant = 1'b1;
        wait_idle("t2_done");
        tick();
        grant = 1'b0;
        chk("t2_count",      32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("t2_flit", got[i], f2[i]);
        chk("t2_empty_id",   32'(flit_id),   32'd0);

        // 3: stray body flit ahead of a packet is dropped with one err pulse
        got.delete();
        n_err = 0;
        grant = 1'b1;
        in_valid = 1'b1;
        in_flit = mk(ID_BODY, 40, 0);
        tick();
        in_flit = mk(ID_HEAD, 41, 2);
        tick();
        chk("t3_err_pulse",  32'(err),       32'd1);
        in_flit = mk(ID_TAIL, 42, 0);
        tick();
        in_valid = 1'b0;
        chk("t3_err_low",    32'(err),       32'd0);
        wait_idle("t3_done");
        tick();
        chk("t3_count",      32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            chk("t3_h", got[0], mk(ID_HEAD, 41, 2));
            chk("t3_t", got[1], mk(ID_TAIL, 42, 0));
        end
        chk("t3_err_cnt",    32'(n_err),     32'd1);
        chk("t3_length",     32'(length),    32'd2);

        // 4: grant pattern 1,0,0,1,1,1 over a 4-flit packet
        got.delete();
        grant = 1'b0;
        f4[0] = mk(ID_HEAD, 50, 4);
        f4[1] = mk(ID_BODY, 51, 0);
        f4[2] = mk(ID_BODY, 52, 0);
        f4[3] = mk(ID_TAIL, 53, 0);
        g4 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_flit  = f4[i];
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            grant = g4[k];
            tick();
            chk("t4_ov", 32'(out_valid), 32'(g4[k]));
            chk("t4_req", 32'(req), (k < 5) ? 32'd1 : 32'd0);
        end
        grant = 1'b0;
        tick();
        chk("t4_count",      32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("t4_flit", got[i], f4[i]);

        // 5: 20 three-flit packets with random in_valid/grant, crossing the pointer wrap
        got.delete();
        n_err = 0;
        for (int p = 0; p < 20; p++) begin
            f5[3*p]   = mk(ID_HEAD, 100 + 3*p, 3);
            f5[3*p+1] = mk(ID_BODY, 101 + 3*p, 0);
            f5[3*p+2] = mk(ID_TAIL, 102 + 3*p, 0);
        end
        idx = 0;
        for (int c = 0; c < 3000; c++) begin
            if (idx == 60 && got.size() == 60 && !req) break;
            in_valid = (idx < 60) && ($urandom % 2 == 0);
            in_flit  = (idx < 60) ? f5[idx] : 32'd0;
            grant    = ($urandom % 4) != 0;
            #0;
            acc = in_valid & in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        grant = 1'b0;
        tick();
        chk("t5_pushed",     32'(idx),        32'd60);
        chk("t5_count",      32'(got.size()), 32'd60);
        for (int i = 0; i < 60 && i < got.size(); i++) chk("t5_flit", got[i], f5[i]);
        chk("t5_err_cnt",    32'(n_err),     32'd0);

        // 6: reset in XFER with 3 flits still buffered
        n_err = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_flit  = mk((i == 0) ? ID_HEAD : ((i == 4) ? ID_TAIL : ID_BODY), 200 + i, 5);
            tick();
        end
        in_valid = 1'b0;
        grant = 1'b1;
        tick();
        tick();
        grant = 1'b0;
        chk("t6_pre_req",    32'(req),       32'd1);
        chk("t6_pre_id",     32'(flit_id),   32'(ID_BODY));
        rst = 1'b1;
        tick();
        chk("t6_req",        32'(req),       32'd0);
        chk("t6_out_valid",  32'(out_valid), 32'd0);
        chk("t6_in_ready",   32'(in_ready),  32'd1);
        chk("t6_flit_id",    32'(flit_id),   32'd0);
        chk("t6_err",        32'(err),       32'd0);
        rst = 1'b0;
        grant = 1'b1;
        tick();
        tick();
        chk("t6_post_req",   32'(req),       32'd0);
        chk("t6_post_ov",    32'(out_valid), 32'd0);
        chk("t6_post_err",   32'(n_err),     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
